// File: rtl/fifo_burst_reader.sv
// Burst read controller for fifo_top: pops cmd_len words, hides the FIFO's
// one-cycle read latency behind a 2-entry skid buffer, streams valid/ready.
module fifo_burst_reader #(
  parameter int N     = 3,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             fifo_empty,
  output logic             fifo_re,
  input  logic [N-1:0]     fifo_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N-1:0]     m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] issue_cnt, issue_cnt_nxt;
  logic [LEN_W-1:0] out_cnt, out_cnt_nxt;
  logic [1:0]       occ, occ_nxt, occ_left;
  logic             inflight;
  logic [N-1:0]     sb0, sb1, sb0_nxt, sb1_nxt;
  logic             pop;
  logic [2:0]       level;

  assign m_valid   = (occ != 2'd0);
  assign m_data    = sb0;
  assign m_last    = m_valid && (out_cnt == LEN_W'(1));
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Words already held or on their way, net of this cycle's pop, must leave
  // room for the word a read issued now will deliver.
  always_comb begin
    pop     = m_valid && m_ready;
    level   = 3'(occ) + 3'(inflight) - 3'(pop);
    fifo_re = (state == S_READ) && (issue_cnt != '0) && !fifo_empty && (level < 3'd2);
  end

  always_comb begin
    state_nxt     = state;
    issue_cnt_nxt = issue_cnt;
    out_cnt_nxt   = out_cnt;
    sb0_nxt       = sb0;
    sb1_nxt       = sb1;
    occ_left      = occ - {1'b0, pop};
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len != '0) begin
            issue_cnt_nxt = cmd_len;
            out_cnt_nxt   = cmd_len;
            state_nxt     = S_READ;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_READ: begin
        if (fifo_re) issue_cnt_nxt = issue_cnt - LEN_W'(1);
        if (pop) begin
          out_cnt_nxt = out_cnt - LEN_W'(1);
          if (m_last) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Head shifts out on pop; the arriving word lands behind whatever remains.
    if (pop) sb0_nxt = sb1;
    if (inflight) begin
      if (occ_left == 2'd0) sb0_nxt = fifo_out;
      else                  sb1_nxt = fifo_out;
    end
    occ_nxt = occ_left + {1'b0, inflight};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
      out_cnt   <= '0;
      occ       <= '0;
      inflight  <= 1'b0;
      sb0       <= '0;
      sb1       <= '0;
    end else begin
      state     <= state_nxt;
      issue_cnt <= issue_cnt_nxt;
      out_cnt   <= out_cnt_nxt;
      occ       <= occ_nxt;
      inflight  <= fifo_re;
      sb0       <= sb0_nxt;
      sb1       <= sb1_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO plus a burst-level stream
// model checked every cycle, directed scenarios and randomized bursts.
module tb_fifo_burst_reader;
  localparam int N     = 3;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_re;
  logic [N-1:0]     fifo_out = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [N-1:0]     m_data;
  logic             m_last;
  logic             busy;
  logic             done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .fifo_out(fifo_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural fifo_top: one-cycle read latency, writes visible next cycle
  logic [N-1:0] fq[$];
  logic [N-1:0] wr_q[$];
  logic [N-1:0] exp_q[$];
  logic         re_s = 1'b0;

  function automatic void wr(logic [N-1:0] v);
    wr_q.push_back(v);
    exp_q.push_back(v);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      wr_q.delete();
      fifo_out   <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (re_s && fq.size() != 0) fifo_out <= fq.pop_front();
      while (wr_q.size() != 0) fq.push_back(wr_q.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Consumer readiness patterns and a background random writer
  int rmode = 0;
  int rphase = 0;
  int wr_budget = 0;
  always @(negedge clk) begin
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = (rphase % 3 == 0);
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
    rphase++;
    if (wr_budget > 0 && rst_n && $urandom_range(0, 2) == 0) begin
      wr(N'($urandom));
      wr_budget--;
    end
  end

  // Stream model: a burst of L words delivers the next L written words in
  // order, last flagged, done one cycle after the last handshake.
  int cyc = 0, acc_cyc = 0, first_v = -1, last_cyc = 0, done_cyc = 0;
  int acc_cnt = 0, done_cnt = 0;
  int burst_len = 0, m_rem = 0, re_cnt = 0, burst_re = 0;
  int issued = 0, popped = 0;
  bit busy_exp = 0, in_read = 0, exp_done = 0, hold = 0, last_prev = 0;
  bit pop, nxt_busy, nxt_done;
  logic [N-1:0] data_prev = '0;
  logic [N-1:0] exp_word;
  logic [N-1:0] hs_q[$];

  always @(negedge clk) begin
    #1;
    cyc++;
    re_s = fifo_re;
    if (!rst_n) begin
      busy_exp = 0; in_read = 0; exp_done = 0; hold = 0;
      issued = 0; popped = 0;
      exp_q.delete();
    end else begin
      pop = m_valid && m_ready;
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("cmd_ready", 32'(cmd_ready), 32'(!busy_exp));
      chk("re_while_empty", 32'(fifo_re && fifo_empty), 0);
      chk("re_beyond_len", 32'(fifo_re && !(in_read && re_cnt < burst_len)), 0);
      chk("valid_outside_burst", 32'(m_valid && !in_read), 0);
      chk("m_last", 32'(m_last), 32'(m_valid && in_read && m_rem == 1));
      if (hold) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 32'(data_prev));
        chk("hold_last", 32'(m_last), 32'(last_prev));
      end
      if (m_valid && in_read && first_v < 0) first_v = cyc;
      if (pop && in_read) begin
        exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        chk("m_data", 32'(m_data), 32'(exp_word));
        hs_q.push_back(m_data);
        last_cyc = cyc;
        m_rem--;
      end
      if (in_read) re_cnt += 32'(fifo_re);
      issued += 32'(fifo_re);
      popped += 32'(pop);
      chk("buffered_le2", 32'((issued - popped) <= 2), 1);

      nxt_done = 0;
      nxt_busy = busy_exp;
      if (exp_done) begin
        chk("re_count", re_cnt, burst_len);
        burst_re = re_cnt;
        nxt_busy = 0;
        done_cnt++;
        done_cyc = cyc;
      end
      if (in_read && pop && m_rem == 0) begin
        in_read  = 0;
        nxt_done = 1;
      end
      if (!busy_exp && cmd_valid) begin
        acc_cnt++;
        acc_cyc   = cyc;
        burst_len = int'(cmd_len);
        re_cnt    = 0;
        first_v   = -1;
        hs_q.delete();
        nxt_busy  = 1;
        if (cmd_len == '0) nxt_done = 1;
        else begin
          in_read = 1;
          m_rem   = int'(cmd_len);
        end
      end
      exp_done  = nxt_done;
      busy_exp  = nxt_busy;
      hold      = m_valid && !m_ready;
      data_prev = m_data;
      last_prev = m_last;
    end
  end

  task automatic send_cmd(input int len);
    int a0;
    bit ok;
    a0 = acc_cnt;
    ok = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (acc_cnt != a0) ok = 1;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept_timeout", 32'(ok), 1);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done_cnt != d0) ok = 1;
    end
    chk("done_timeout", 32'(ok), 1);
  endtask

  task automatic check_seq(input string tag, input int base, input int n);
    chk(tag, hs_q.size(), n);
    for (int i = 0; i < n && i < hs_q.size(); i++)
      chk(tag, 32'(hs_q[i]), 32'((base + i) % 8));
  endtask

  initial begin
    int len;
    bit ok;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fifo_re", 32'(fifo_re), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_data", 32'(m_data), 0);

    // Basic burst: preloaded 0..7, full throughput
    rmode = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) wr(N'(i));
    repeat (2) @(negedge clk);
    send_cmd(8);
    wait_done(200);
    chk("basic_latency", first_v - acc_cyc, 3);
    chk("basic_span", last_cyc - first_v, 7);
    chk("basic_done_lag", done_cyc - last_cyc, 1);
    chk("basic_re_pulses", burst_re, 8);
    check_seq("basic_data", 0, 8);

    // Backpressure: m_ready pattern 1,0,0 repeating
    @(negedge clk);
    for (int i = 0; i < 5; i++) wr(N'(i));
    rphase = 0;
    rmode  = 1;
    send_cmd(5);
    wait_done(300);
    check_seq("bp_data", 0, 5);
    rmode = 0;

    // Empty mid-burst: 3 words now, 3 more ten cycles later
    @(negedge clk);
    for (int i = 1; i <= 3; i++) wr(N'(i));
    send_cmd(6);
    repeat (10) @(negedge clk);
    for (int i = 4; i <= 6; i++) wr(N'(i));
    wait_done(300);
    check_seq("empty_data", 1, 6);

    // Zero length
    send_cmd(0);
    wait_done(20);
    chk("zero_done_lat", done_cyc - acc_cyc, 1);
    chk("zero_words", hs_q.size(), 0);
    chk("zero_re", burst_re, 0);

    // Reset during word 3 of an 8-word burst
    @(negedge clk);
    for (int i = 0; i < 8; i++) wr(N'(i));
    send_cmd(8);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (hs_q.size() >= 2) ok = 1;
      else @(negedge clk);
    end
    chk("mid_reset_reach_word3", 32'(ok), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_reset_m_valid", 32'(m_valid), 0);
    chk("mid_reset_fifo_re", 32'(fifo_re), 0);
    chk("mid_reset_busy", 32'(busy), 0);
    chk("mid_reset_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    wr(N'(5));
    wr(N'(6));
    send_cmd(2);
    wait_done(100);
    check_seq("post_reset_data", 5, 2);

    // Randomized bursts with random backpressure and trickling writes
    rmode = 2;
    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(0, 12);
      wr_budget += len;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_cmd(len);
      wait_done(2000);
      chk("rand_words", hs_q.size(), len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for `fifo_top`: it accepts a burst command of `cmd_len` words and pops exactly that many words from the FIFO. It absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer and presents the words on a valid/ready stream, flagging the final word with `m_last`. It sits between `fifo_top` (`re`/`empty`/`out`) and any downstream consumer that can apply backpressure.

## Interface
- `N`, 3, data width; matches `fifo_top` `N`.
- `LEN_W`, 8, width of burst length and counters.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: burst command offered.
- `cmd_ready` out 1: controller idle and able to accept a command.
- `cmd_len` in LEN_W: words in burst; sampled on `cmd_valid && cmd_ready`.
- `fifo_empty` in 1: from `fifo_top` `empty`.
- `fifo_re` out 1: to `fifo_top` `re`; combinational.
- `fifo_out` in N: from `fifo_top` `out`; valid the cycle after `fifo_re=1`.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out N: output word.
- `m_last` out 1: the current word is the last word of the burst.
- `busy` out 1: a burst is in progress.
- `done` out 1: one-cycle pulse at burst completion.

## Operation
- **States**
  - IDLE: `cmd_ready=1`. On accept with `cmd_len!=0`, load `issue_cnt=out_cnt=cmd_len` and go to READ. On accept with `cmd_len==0`, go to DONE.
  - READ: issue FIFO reads and stream words out. After the handshake of the word with `m_last=1`, go to DONE.
  - DONE: one cycle; `done=1`, then go to IDLE.
- **Read issue**
  - `fifo_re = READ && issue_cnt!=0 && !fifo_empty && (occ + inflight - pop) < 2`.
  - `occ` is skid buffer occupancy (0..2).
  - `inflight` is `fifo_re` registered.
  - `pop = m_valid && m_ready`.
  - `issue_cnt` decrements on each `fifo_re`.
  - The controller never asserts `re` while `fifo_empty=1`, and never issues more than `cmd_len` reads.
- **Capture**
  - When `inflight=1`, `fifo_out` is written into the buffer tail in that cycle.
  - The buffer is FIFO-ordered, depth 2. The issue rule guarantees it never overflows.
- **Output**
  - `m_valid = occ!=0`.
  - `m_data` is the buffer head.
  - `m_last = m_valid && out_cnt==1`.
  - `out_cnt` decrements on `pop`.
  - While `m_valid && !m_ready`, `m_data` and `m_last` hold stable.
- `busy = state!=IDLE`. `cmd_valid` is ignored while busy.
- **Width**
  - Counters are LEN_W bits.
  - Maximum burst is 2^LEN_W-1 words.
  - No wrap: counters never decrement below 0.

## Timing
- **Reset values** (synchronous, applied at the clk edge with `rst_n=0`):
  - state=IDLE; `cmd_ready=1`, `busy=0`, `done=0`.
  - `fifo_re=0`, `m_valid=0`, `m_last=0`, `m_data=0`.
  - `occ=0`, `inflight=0`, counters 0.
- **Latency**
  - Command accepted in cycle T: earliest `fifo_re` in T+1, data on `fifo_out` in T+2, first `m_valid` in T+3.
  - Throughput is 1 word/clk with `m_ready=1` and FIFO non-empty. This includes `occ=1, inflight=1` with a simultaneous pop.
- **Completion**
  - Last-word handshake in cycle L: `done=1` and `busy=1` in L+1; `cmd_ready=1` in L+2.
  - A `cmd_len=0` command accepted in T gives `done` in T+1, with no `fifo_re` and no `m_valid`.
- **Empty mid-burst**: `fifo_re` drops while `fifo_empty=1`, then resumes the cycle `empty` falls. Buffered words keep draining.
- **Backpressure**
  - With `m_ready=0`, at most 2 words are buffered and `fifo_re` stays 0 until a pop.
  - On the release cycle, pop and re may coincide.
- **Reset mid-burst**
  - All state is cleared and buffered or in-flight words are discarded.
  - `fifo_out` in the cycle after reset is ignored.
  - `fifo_top` is reset by the same `rst_n`.

## Test plan
- **Basic burst.** Reset, FIFO preloaded 0..7 (N=3), cmd_len=8, `m_ready=1`.
  - Required: first `m_valid` at T+3, `m_data` 0..7 on consecutive cycles.
  - Required: `m_last` only on word 7, `done` one cycle later, exactly 8 `fifo_re` pulses.
- **Backpressure.** cmd_len=5, `m_ready` toggled 1,0,0,1,...
  - Required: `m_data` stable while stalled, `occ` never exceeds 2, output sequence 0..4 with no loss or duplication.
- **Empty mid-burst.** FIFO holds 3 words, cmd_len=6, 3 more words written 10 cycles later.
  - Required: `fifo_re` never asserted while `empty=1`.
  - Required: all 6 words delivered in order, `m_last` on the 6th.
- **Zero length.** cmd_len=0.
  - Required: `done` at T+1, `cmd_ready` back at T+2, no `fifo_re`, no `m_valid`.
- **Reset mid-burst.** Assert `rst_n=0` for 1 cycle during word 3 of an 8-word burst.
  - Required: next cycle shows `m_valid=0`, `fifo_re=0`, `busy=0`, `cmd_ready=1`.
  - Required: a new 2-word burst then completes normally.
